fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue RV32I core, directly upstream of the 64-word instruction memory. It owns the program counter and drives the word address into the memory. It captures the combinational instruction word into the IF/ID pipeline register and hands it to decode with a valid flag. It also applies stall, branch/jump redirect with flush, a start gate and a sticky halt on misaligned redirect targets.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory word
// address and captures the fetched word into the IF/ID register. Supports
// stall, redirect with flush, a start gate and a sticky misaligned-target halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        misaligned;

    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: misaligned redirect beats start; HALT is terminal
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (misaligned) begin
                    state_d = StHalt;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (misaligned) begin
                    state_d = StHalt;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        halted = (state_q == StHalt);
    end

    // Datapath next values: misaligned > redirect > stall > advance
    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        fetch_count_d = fetch_count_q;
        if (state_q != StHalt) begin
            if (misaligned) begin
                if_valid_d = 1'b0;
                if_inst_d  = NOP_INST;
            end else if (redirect) begin
                // Flush the wrong-path word; target is fetched next edge
                pc_d       = redirect_pc;
                if_valid_d = 1'b0;
                if_inst_d  = NOP_INST;
            end else if ((state_q == StRun) && !stall) begin
                if_inst_d     = imem_data;
                if_pc_d       = pc_q;
                if_pc_plus4_d = pc_q + 32'd4;
                if_valid_d    = 1'b1;
                pc_d          = pc_q + 32'd4;
                if (fetch_count_q != 16'hFFFF) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                end
            end
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_inst_q     <= NOP_INST;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            fetch_count_q <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Output mapping; byte addresses wrap every 256 bytes onto the 64-word memory
    always_comb begin
        imem_addr   = pc_q[7:2];
        if_valid    = if_valid_q;
        if_inst     = if_inst_q;
        if_pc       = if_pc_q;
        if_pc_plus4 = if_pc_plus4_q;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 64-word behavioural memory.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    int          n_cmp;
    int          n_err;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_inst"}, if_inst, NOP);
        check({tag, "_pc"}, if_pc, 32'd0);
        check({tag, "_pc4"}, if_pc_plus4, 32'd0);
        check({tag, "_halt"}, {31'd0, halted}, 32'd0);
        check({tag, "_cnt"}, {16'd0, fetch_count}, 32'd0);
        check({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0010_0F93;
        mem[1] = 32'h0000_2083;
        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        check_reset_state("rst");

        // Start: no capture on the start edge, then one per cycle
        rst = 1'b0;
        start = 1'b1;
        check("pre_start_valid", {31'd0, if_valid}, 32'd0);
        step();
        start = 1'b0;
        check("start_edge_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("f0_valid", {31'd0, if_valid}, 32'd1);
        check("f0_pc", if_pc, 32'd0);
        check("f0_inst", if_inst, 32'h0010_0F93);
        check("f0_pc4", if_pc_plus4, 32'd4);
        step();
        check("f1_pc", if_pc, 32'd4);
        check("f1_inst", if_inst, 32'h0000_2083);
        check("f1_cnt", {16'd0, fetch_count}, 32'd2);
        step();
        check("f2_pc", if_pc, 32'd8);

        // Stall holds everything for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", if_pc, 32'd8);
            check("stall_addr", {26'd0, imem_addr}, 32'd3);
            check("stall_inst", if_inst, mem[2]);
            check("stall_cnt", {16'd0, fetch_count}, 32'd3);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", if_pc, 32'd12);
        check("unstall_inst", if_inst, mem[3]);
        check("unstall_cnt", {16'd0, fetch_count}, 32'd4);

        // Redirect wins over simultaneous stall
        redirect = 1'b1; redirect_pc = 32'h50; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("redir_valid", {31'd0, if_valid}, 32'd0);
        check("redir_inst", if_inst, NOP);
        check("redir_addr", {26'd0, imem_addr}, 32'd20);
        step();
        check("redir_tgt_pc", if_pc, 32'h50);
        check("redir_tgt_inst", if_inst, mem[20]);
        check("redir_tgt_valid", {31'd0, if_valid}, 32'd1);
        check("redir_cnt", {16'd0, fetch_count}, 32'd5);

        // Byte address 0x100 aliases word 0
        redirect = 1'b1; redirect_pc = 32'hFC;
        step();
        redirect = 1'b0;
        step();
        check("wrapfc_pc", if_pc, 32'hFC);
        check("wrapfc_inst", if_inst, mem[63]);
        check("wrapfc_addr", {26'd0, imem_addr}, 32'd0);
        step();
        check("wrap100_pc", if_pc, 32'h100);
        check("wrap100_inst", if_inst, 32'h0010_0F93);
        check("wrap100_pc4", if_pc_plus4, 32'h104);

        // 32-bit PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        check("pcwrap_pc", if_pc, 32'hFFFF_FFFC);
        check("pcwrap_pc4", if_pc_plus4, 32'd0);
        check("pcwrap_addr", {26'd0, imem_addr}, 32'd0);
        step();
        check("pcwrap_next_pc", if_pc, 32'd0);
        check("pcwrap_cnt", {16'd0, fetch_count}, 32'd9);

        // Misaligned redirect halts; later inputs ignored
        redirect = 1'b1; redirect_pc = 32'h52;
        step();
        check("mis_halt", {31'd0, halted}, 32'd1);
        check("mis_valid", {31'd0, if_valid}, 32'd0);
        check("mis_inst", if_inst, NOP);
        check("mis_addr", {26'd0, imem_addr}, 32'd1);
        start = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_halt", {31'd0, halted}, 32'd1);
            check("halt_valid", {31'd0, if_valid}, 32'd0);
            check("halt_addr", {26'd0, imem_addr}, 32'd1);
            check("halt_cnt", {16'd0, fetch_count}, 32'd9);
        end
        start = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("halt_rst");

        // Redirect in IDLE moves pc but does not fetch
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        check("idle_redir_addr", {26'd0, imem_addr}, 32'd8);
        step();
        check("idle_hold_valid", {31'd0, if_valid}, 32'd0);
        check("idle_hold_addr", {26'd0, imem_addr}, 32'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("idle_start_pc", if_pc, 32'h20);
        check("idle_start_inst", if_inst, mem[8]);

        // Saturation of fetch_count
        for (int i = 0; i < 65533; i++) @(posedge clk);
        #1;
        check("sat_fffe", {16'd0, fetch_count}, 32'h0000_FFFE);
        step();
        check("sat_ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("sat_hold", {16'd0, fetch_count}, 32'h0000_FFFF);

        // Reset during a stall
        stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_reset_state("stall_rst");
        rst = 1'b0; stall = 1'b0;
        step();
        check("post_rst_idle_valid", {31'd0, if_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
